// File: rtl/exe_stage.sv
// Execute stage with EXE/MEM register and NZCV status; Val2 shifter, ALU, branch target.
// Latency: br_taken/br_addr combinational, alu_res/sr one cycle; freeze holds all state, no backpressure otherwise.
// Optional operand forwarding from MEM/WB compiled in with `define EXE_FORWARDING_EN.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic        b_in,
    input  logic        s_in,
    input  logic        imm_in,
    input  logic [3:0]  exe_cmd_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] val_rn_in,
    input  logic [31:0] val_rm_in,
    input  logic [11:0] shift_operand_in,
    input  logic [23:0] signed_imm_24_in,
    input  logic [3:0]  dest_in,
    input  logic [3:0]  src1_in,
    input  logic [3:0]  src2_in,
    input  logic [31:0] wb_value,
    input  logic [3:0]  wb_dest,
    input  logic        wb_wb_en,
    output logic        br_taken,
    output logic [31:0] br_addr,
    output logic [3:0]  sr,
    output logic        wb_en,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [31:0] alu_res,
    output logic [31:0] st_val,
    output logic [3:0]  dest,
    output logic        fwd_en
);
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    logic [31:0] op1;
    logic [31:0] op_m;
    logic [31:0] val2;
    logic [31:0] b_op;
    logic        cin;
    logic        arith;
    logic [32:0] sum;
    logic [31:0] res;
    logic [3:0]  flags;

    assign br_taken = b_in;
    assign br_addr  = pc_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

`ifdef EXE_FORWARDING_EN
    // MEM stage result is younger than WB, so it takes priority
    always_comb begin
        op1  = val_rn_in;
        op_m = val_rm_in;
        if (wb_en && dest == src1_in)
            op1 = alu_res;
        else if (wb_wb_en && wb_dest == src1_in)
            op1 = wb_value;
        if (wb_en && dest == src2_in)
            op_m = alu_res;
        else if (wb_wb_en && wb_dest == src2_in)
            op_m = wb_value;
    end
    assign fwd_en = 1'b1;
`else
    logic unused_fwd;
    assign op1        = val_rn_in;
    assign op_m       = val_rm_in;
    assign fwd_en     = 1'b0;
    assign unused_fwd = ^{wb_value, wb_dest, wb_wb_en, src1_in, src2_in};
`endif

    logic [4:0]  rot_amt;
    logic [4:0]  sh_amt;
    logic [63:0] imm_dbl;
    logic [63:0] rm_dbl;

    assign rot_amt = {shift_operand_in[11:8], 1'b0};
    assign sh_amt  = shift_operand_in[11:7];
    assign imm_dbl = {2{24'b0, shift_operand_in[7:0]}} >> rot_amt;
    assign rm_dbl  = {op_m, op_m} >> sh_amt;

    always_comb begin
        val2 = op_m;
        if (mem_r_en_in || mem_w_en_in)
            val2 = {20'b0, shift_operand_in};
        else if (imm_in)
            val2 = imm_dbl[31:0];
        else begin
            case (shift_operand_in[6:5])
                2'b00:   val2 = op_m << sh_amt;
                2'b01:   val2 = op_m >> sh_amt;
                2'b10:   val2 = $unsigned($signed(op_m) >>> sh_amt);
                default: val2 = rm_dbl[31:0];
            endcase
        end
    end

    // Subtraction is op1 + ~val2 + cin so carry means "no borrow"
    always_comb begin
        arith = 1'b0;
        b_op  = val2;
        cin   = 1'b0;
        res   = 32'b0;
        case (exe_cmd_in)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_ADD: arith = 1'b1;
            CMD_ADC: begin arith = 1'b1; cin = sr[1]; end
            CMD_SUB: begin arith = 1'b1; b_op = ~val2; cin = 1'b1; end
            CMD_SBC: begin arith = 1'b1; b_op = ~val2; cin = sr[1]; end
            CMD_AND: res = op1 & val2;
            CMD_ORR: res = op1 | val2;
            CMD_EOR: res = op1 ^ val2;
            default: res = 32'b0;
        endcase
        sum = {1'b0, op1} + {1'b0, b_op} + {32'b0, cin};
        if (arith)
            res = sum[31:0];
    end

    always_comb begin
        flags[3] = res[31];
        flags[2] = (res == 32'b0);
        flags[1] = arith ? sum[32] : sr[1];
        flags[0] = arith ? ((op1[31] == b_op[31]) && (sum[31] != op1[31])) : sr[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr       <= 4'b0;
            wb_en    <= 1'b0;
            mem_r_en <= 1'b0;
            mem_w_en <= 1'b0;
            alu_res  <= 32'b0;
            st_val   <= 32'b0;
            dest     <= 4'b0;
        end else if (!freeze) begin
            if (s_in)
                sr <= flags;
            wb_en    <= wb_en_in;
            mem_r_en <= mem_r_en_in;
            mem_w_en <= mem_w_en_in;
            alu_res  <= res;
            st_val   <= op_m;
            dest     <= dest_in;
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: vector table for ALU/shifter/flags, hand sequences for
// reset, branch, forwarding, freeze and asynchronous reset.
module tb_exe_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
    logic [3:0]  exe_cmd_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  dest_in, src1_in, src2_in;
    logic [31:0] wb_value;
    logic [3:0]  wb_dest;
    logic        wb_wb_en;
    logic        br_taken;
    logic [31:0] br_addr;
    logic [3:0]  sr;
    logic        wb_en, mem_r_en, mem_w_en;
    logic [31:0] alu_res, st_val;
    logic [3:0]  dest;
    logic        fwd_en;

    int tests = 0;
    int fails = 0;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .exe_cmd_in(exe_cmd_in),
        .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
        .wb_value(wb_value), .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
        .br_taken(br_taken), .br_addr(br_addr), .sr(sr),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .alu_res(alu_res), .st_val(st_val), .dest(dest), .fwd_en(fwd_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic        imm, s, wb, mr, mw;
        logic [11:0] so;
        logic [31:0] rn, rm;
        logic [31:0] exp_res;
        logic [3:0]  exp_sr;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic [3:0] cmd, input logic imm, input logic s,
                                input logic wb, input logic mr, input logic mw,
                                input logic [11:0] so, input logic [31:0] rn,
                                input logic [31:0] rm, input logic [31:0] exp_res,
                                input logic [3:0] exp_sr);
        vec_t v;
        v.cmd = cmd; v.imm = imm; v.s = s; v.wb = wb; v.mr = mr; v.mw = mw;
        v.so = so; v.rn = rn; v.rm = rm; v.exp_res = exp_res; v.exp_sr = exp_sr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bubble();
        wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0; imm_in = 0;
        exe_cmd_in = 0; pc_in = 0; val_rn_in = 0; val_rm_in = 0; shift_operand_in = 0;
        signed_imm_24_in = 0; dest_in = 0; src1_in = 0; src2_in = 0;
        wb_value = 0; wb_dest = 0; wb_wb_en = 0;
    endtask

    task automatic apply(input vec_t v);
        exe_cmd_in = v.cmd; imm_in = v.imm; s_in = v.s; wb_en_in = v.wb;
        mem_r_en_in = v.mr; mem_w_en_in = v.mw; shift_operand_in = v.so;
        val_rn_in = v.rn; val_rm_in = v.rm;
        dest_in = 4'd14; src1_in = 4'd2; src2_in = 4'd3; wb_wb_en = 0;
    endtask

    logic exp_fwd;
    logic [31:0] exp_a, exp_b, exp_c;

    initial begin
        //                cmd    imm s  wb mr mw so       rn            rm            result        sr
        vecs[0]  = mk(4'b0001, 1, 1, 1, 0, 0, 12'h2FF, 32'h0,        32'h0,        32'hF000000F, 4'b1000);
        vecs[1]  = mk(4'b0100, 1, 1, 1, 0, 0, 12'h005, 32'd5,        32'h0,        32'h0,        4'b0110);
        vecs[2]  = mk(4'b0011, 1, 0, 1, 0, 0, 12'h001, 32'd1,        32'h0,        32'd3,        4'b0110);
        vecs[3]  = mk(4'b0010, 1, 1, 1, 0, 0, 12'h001, 32'h7FFFFFFF, 32'h0,        32'h80000000, 4'b1001);
        vecs[4]  = mk(4'b1001, 1, 1, 1, 0, 0, 12'h000, 32'h0,        32'h0,        32'hFFFFFFFF, 4'b1001);
        vecs[5]  = mk(4'b0001, 0, 0, 1, 0, 0, 12'h200, 32'h0,        32'h1,        32'h10,       4'b1001);
        vecs[6]  = mk(4'b0001, 0, 0, 1, 0, 0, 12'hFA0, 32'h0,        32'h80000000, 32'h1,        4'b1001);
        vecs[7]  = mk(4'b0001, 0, 0, 1, 0, 0, 12'h240, 32'h0,        32'h80000000, 32'hF8000000, 4'b1001);
        vecs[8]  = mk(4'b0001, 0, 0, 1, 0, 0, 12'h460, 32'h0,        32'h000000FF, 32'hFF000000, 4'b1001);
        vecs[9]  = mk(4'b0001, 0, 0, 1, 0, 0, 12'h060, 32'h0,        32'h12345678, 32'h12345678, 4'b1001);
        vecs[10] = mk(4'b0010, 1, 0, 0, 0, 1, 12'hFFF, 32'h1000,     32'hCAFEBABE, 32'h1FFF,     4'b1001);
        vecs[11] = mk(4'b0101, 1, 1, 1, 0, 0, 12'h003, 32'd10,       32'h0,        32'd6,        4'b0010);
        vecs[12] = mk(4'b0110, 1, 1, 1, 0, 0, 12'h0FF, 32'hF0F0F0F0, 32'h0,        32'hF0,       4'b0010);
        vecs[13] = mk(4'b0111, 1, 0, 1, 0, 0, 12'h00F, 32'h100,      32'h0,        32'h10F,      4'b0010);
        vecs[14] = mk(4'b1000, 1, 0, 1, 1, 0, 12'h00F, 32'hFF,       32'h0,        32'h0F,       4'b0010);
        vecs[15] = mk(4'b0000, 1, 0, 1, 0, 0, 12'h0FF, 32'h1234,     32'h0,        32'h0,        4'b0010);
        vecs[16] = mk(4'b0100, 1, 1, 0, 0, 0, 12'h005, 32'd3,        32'h0,        32'hFFFFFFFE, 4'b1000);
        // vecs[14] sets mem_r_en, so Val2 is the raw 12-bit offset 0xF and 0xFF ^ 0xF = 0xF0
        vecs[14].exp_res = 32'hF0;

`ifdef EXE_FORWARDING_EN
        exp_fwd = 1'b1;
`else
        exp_fwd = 1'b0;
`endif

        rst = 1; freeze = 0;
        bubble();
        #2;
        chk("reset alu_res", alu_res, 32'h0);
        chk("reset sr", {28'b0, sr}, 32'h0);
        chk("reset ctrl", {29'b0, wb_en, mem_r_en, mem_w_en}, 32'h0);
        chk("reset st_val/dest", {st_val[27:0], dest}, 32'h0);
        chk("fwd_en", {31'b0, fwd_en}, {31'b0, exp_fwd});
        @(negedge clk);
        rst = 0;

        pc_in = 32'h100; signed_imm_24_in = 24'hFFFFFE; b_in = 1;
        #1;
        chk("br_addr back", br_addr, 32'hF8);
        chk("br_taken 1", {31'b0, br_taken}, 32'h1);
        signed_imm_24_in = 24'h000003; b_in = 0;
        #1;
        chk("br_addr fwd", br_addr, 32'h10C);
        chk("br_taken 0", {31'b0, br_taken}, 32'h0);
        @(negedge clk);
        bubble();

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i]);
            tick();
            chk($sformatf("v%0d alu_res", i), alu_res, vecs[i].exp_res);
            chk($sformatf("v%0d sr", i), {28'b0, sr}, {28'b0, vecs[i].exp_sr});
            chk($sformatf("v%0d st_val", i), st_val, vecs[i].rm);
            chk($sformatf("v%0d ctrl", i), {27'b0, wb_en, mem_r_en, mem_w_en, dest},
                {27'b0, vecs[i].wb, vecs[i].mr, vecs[i].mw, 4'd14});
        end

        // Forwarding: r1 = 0x15 into MEM, then consumers with stale register values
        bubble();
        exe_cmd_in = 4'b0010; imm_in = 1; shift_operand_in = 12'h005; val_rn_in = 32'h10;
        wb_en_in = 1; dest_in = 4'd1; src1_in = 4'd0; src2_in = 4'd15;
        tick();
        chk("fwd setup", alu_res, 32'h15);
        exp_a = exp_fwd ? 32'h16 : 32'h101;
        exp_b = exp_fwd ? 32'h16 : 32'h7;
        exp_c = exp_fwd ? 32'h41 : 32'h101;
        val_rn_in = 32'h100; shift_operand_in = 12'h001; src1_in = 4'd1; dest_in = 4'd2;
        wb_wb_en = 1; wb_dest = 4'd1; wb_value = 32'hDEAD;
        tick();
        chk("fwd mem over wb", alu_res, exp_a);
        exe_cmd_in = 4'b0001; imm_in = 0; shift_operand_in = 12'h000; val_rm_in = 32'h7;
        src1_in = 4'd0; src2_in = 4'd2; dest_in = 4'd3; wb_wb_en = 0;
        tick();
        chk("fwd rm from mem", alu_res, exp_b);
        chk("fwd st_val", st_val, exp_b);
        exe_cmd_in = 4'b0010; imm_in = 1; shift_operand_in = 12'h001; val_rn_in = 32'h100;
        src1_in = 4'd1; src2_in = 4'd15; dest_in = 4'd4;
        wb_wb_en = 1; wb_dest = 4'd1; wb_value = 32'h40;
        tick();
        chk("fwd from wb", alu_res, exp_c);

        // Freeze: ADC held for three cycles must not update alu_res or sr
        bubble();
        exe_cmd_in = 4'b0010; imm_in = 1; shift_operand_in = 12'h001; val_rn_in = 32'h1;
        s_in = 1; wb_en_in = 1; dest_in = 4'd14; src1_in = 4'd2; src2_in = 4'd3;
        tick();
        chk("frz pre alu_res", alu_res, 32'h2);
        chk("frz pre sr", {28'b0, sr}, 32'h0);
        exe_cmd_in = 4'b0011; val_rn_in = 32'hFFFFFFFF; freeze = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("frz%0d alu_res", c), alu_res, 32'h2);
            chk($sformatf("frz%0d sr", c), {28'b0, sr}, 32'h0);
        end
        freeze = 0;
        tick();
        chk("frz release alu_res", alu_res, 32'h0);
        chk("frz release sr", {28'b0, sr}, 32'h6);
        bubble();
        tick();
        chk("bubble sr", {28'b0, sr}, 32'h6);
        chk("bubble ctrl", {29'b0, wb_en, mem_r_en, mem_w_en}, 32'h0);

        // Asynchronous reset in the middle of a frozen sequence
        apply(vecs[0]);
        tick();
        chk("pre-rst alu_res", alu_res, 32'hF000000F);
        freeze = 1;
        #2 rst = 1;
        #1;
        chk("async rst alu_res", alu_res, 32'h0);
        chk("async rst sr", {28'b0, sr}, 32'h0);
        chk("async rst ctrl", {25'b0, wb_en, mem_r_en, mem_w_en, dest}, 32'h0);
        chk("async rst st_val", st_val, 32'h0);
        @(negedge clk);
        rst = 0; freeze = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage ARM pipeline, including the EXE/MEM pipeline register. It consumes the registered ID/EX bundle and computes Val2 (immediate rotate, register shift, or memory offset), the ALU result, and the branch target. It also owns the NZCV status register, read by the ID-stage condition check, and registers results toward the MEM stage, honouring the global freeze.

## Interface
- No parameters.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `freeze` in 1: global stall; holds the EXE/MEM register and the status register.
- `wb_en_in`, `mem_r_en_in`, `mem_w_en_in`, `b_in`, `s_in`, `imm_in` in 1 each: ID/EX control bits.
- `exe_cmd_in` in 4: ALU command.
- `pc_in`, `val_rn_in`, `val_rm_in` in 32: PC+4 and register operands.
- `shift_operand_in` in 12: shifter operand field.
- `signed_imm_24_in` in 24: branch offset in words.
- `dest_in`, `src1_in`, `src2_in` in 4: destination register and source register numbers.
- `wb_value` in 32, `wb_dest` in 4, `wb_wb_en` in 1: WB-stage write-back (forwarding source).
- `br_taken` out 1: equals `b_in` (combinational), goes to IF and the flush logic.
- `br_addr` out 32: `pc_in + (sext(signed_imm_24_in) << 2)`, combinational.
- `sr` out 4: {N,Z,C,V}, registered.
- `wb_en`, `mem_r_en`, `mem_w_en` out 1: EXE/MEM control bits.
- `alu_res` out 32: registered ALU result or memory address.
- `st_val` out 32: registered store data (forwarded Rm).
- `dest` out 4: registered destination.
- `fwd_en` out 1: constant; 1 when forwarding is compiled in. Tells the hazard unit to relax stalls.

## Operation
- **Operand select:**
  - `op1` = Rn after forwarding. `op_m` = Rm after forwarding.
  - Forwarding compares `src1_in`/`src2_in` against the registered `dest`, qualified by registered `wb_en`; that MEM match has first priority and sources `alu_res`.
  - Second priority is a match on `wb_dest` qualified by `wb_wb_en`, sourcing `wb_value`.
  - Otherwise the ID value is used.
- **Val2 generation:**
  - If `mem_r_en_in | mem_w_en_in`: `{20'b0, shift_operand_in[11:0]}`.
  - Else if `imm_in`: `{24'b0, shift_operand_in[7:0]}` rotated right by `2*shift_operand_in[11:8]`.
  - Else: `op_m` shifted by `shift_operand_in[11:7]` using type `[6:5]`: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - A shift amount of 0 passes `op_m` unchanged.
- **ALU (`exe_cmd_in`):**
  - 0001 MOV = Val2
  - 1001 MVN = ~Val2
  - 0010 ADD = op1+Val2
  - 0011 ADC = op1+Val2+C
  - 0100 SUB = op1-Val2
  - 0101 SBC = op1-Val2-!C
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - Any other code gives 0.
  - CMP/TST arrive as SUB/AND with `wb_en_in`=0. LDR/STR arrive as ADD.
- **Flags:**
  - N = res[31]; Z = (res==0).
  - Arithmetic: C = carry out of the 33-bit sum, with subtract computed as op1+~Val2+1 (so C=1 means no borrow). V = signed overflow.
  - Logic/MOV/MVN: C and V keep their current SR values.
  - ADC/SBC read the C bit from the registered `sr`, not the newly computed flags.
- **Status register:**
  - Loads {N,Z,C,V} on posedge clk when `s_in & !freeze`. Otherwise holds.
  - A frozen instruction therefore never updates flags twice.
- **EXE/MEM register:**
  - On posedge clk with `!freeze`: loads `{wb_en_in, mem_r_en_in, mem_w_en_in, alu_result, op_m, dest_in}`.
  - With `freeze`: all fields hold.
- Flushed bubbles (all-zero ID/EX bundle) produce `wb_en`=`mem_r_en`=`mem_w_en`=0 and must not touch `sr`, since `s_in`=0.

## Timing
- Reset (async): `sr`=0, `wb_en`=`mem_r_en`=`mem_w_en`=0, `alu_res`=0, `st_val`=0, `dest`=0.
- `br_taken`/`br_addr` are combinational from inputs (zero latency). They are independent of freeze; the flush/freeze policy belongs upstream.
- ALU result appears on `alu_res` one cycle after the instruction is on the inputs.
- Forwarding paths are combinational in the same cycle. MEM forwarding uses this block's own registered outputs.
- A simultaneous MEM and WB match on the same source: MEM wins.
- A match on register 15 forwards like any other register. `rst` mid-freeze: reset dominates.

## Configuration
- `EXE_FORWARDING_EN` defined:
  - Forwarding muxes are active.
  - `fwd_en`=1.
- `EXE_FORWARDING_EN` undefined:
  - `op1`=`val_rn_in` and `op_m`=`val_rm_in` always.
  - `wb_value`/`wb_dest`/`wb_wb_en` are ignored.
  - `fwd_en`=0, and the hazard unit must stall on every RAW dependency.

## Test plan
- **Immediate MOV:** `imm_in`=1, `shift_operand_in`=12'h2FF, MOV -> `alu_res`=32'hF000000F next cycle; with `s_in`=1, `sr`=4'b1000.
- **SUB with flags:** Rn=5, Val2=5, SUB, `s_in`=1 -> `alu_res`=0, `sr`=4'b0110. Then ADC with Rn=1, Val2=1 -> `alu_res`=3.
- **Overflow:** ADD with Rn=32'h7FFFFFFF, Val2=1, `s_in`=1 -> `alu_res`=32'h80000000, `sr`=4'b1001.
- **Forwarding (macro on):** ADD r1 into MEM, then ADD with `src1_in`=1 and stale `val_rn_in` -> the new r1 value is used. The same dest matching both MEM and `wb_dest` -> the MEM value is used. With the macro off -> the stale value is used.
- **Freeze:** hold `freeze`=1 for 3 cycles with `s_in`=1 and an ADC -> `alu_res` and `sr` unchanged during the freeze; a single update after release.
- **Branch:** `pc_in`=32'h100, `signed_imm_24_in`=24'hFFFFFE -> `br_addr`=32'hF8, `br_taken`=`b_in` in the same cycle. Async `rst` mid-sequence -> all registered outputs are 0 immediately.
